snn_frame_scheduler: RTL and testbench

//  Sequences the spiking `network` core over frames of FRAME_LEN input samples.
//  - Buffers incoming spike vectors in a small FIFO and drives start/sample_ready/in_spikes.
//  - Accumulates out_spikes per output neuron over the frame.
//  - Emits argmax class plus counts on a valid/ready result port.
//  - Sits between the sample source and one `network` instance.

---
 rtl/snn_frame_scheduler_if.sv | 43 ++++
 rtl/snn_frame_scheduler.sv | 147 ++++++++++++++
 tb/tb_snn_frame_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_frame_scheduler_if.sv
// Sample, network and result handshakes of snn_frame_scheduler bundled as one interface.
// master = the scheduler itself; slave = the surrounding source / network / consumer.
interface snn_frame_scheduler_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int CNT_W = 8
);
  localparam int CLS_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic                   s_valid;
  logic                   s_ready;
  logic [N_IN-1:0]        s_spikes;

  logic                   net_ready;
  logic                   net_start;
  logic                   net_sample;
  logic                   net_sample_ready;
  logic [N_IN-1:0]        net_in_spikes;
  logic [N_OUT-1:0]       net_out_spikes;

  logic                   res_valid;
  logic                   res_ready;
  logic [CLS_W-1:0]       res_class;
  logic [N_OUT*CNT_W-1:0] res_counts;

  modport master (
    input  s_valid, s_spikes,
    output s_ready,
    input  net_ready, net_sample, net_out_spikes,
    output net_start, net_sample_ready, net_in_spikes,
    input  res_ready,
    output res_valid, res_class, res_counts
  );

  modport slave (
    output s_valid, s_spikes,
    input  s_ready,
    output net_ready, net_sample, net_out_spikes,
    input  net_start, net_sample_ready, net_in_spikes,
    output res_ready,
    input  res_valid, res_class, res_counts
  );
endinterface

// File: rtl/snn_frame_scheduler.sv
// Frame sequencer for one spiking network: input FIFO, per-neuron spike counting, argmax result.
// Optional SNN_SCHED_STALL_CNT_EN adds stall_cycles, counting RUN cycles spent with an empty FIFO.
module snn_frame_scheduler #(
  parameter int N_IN       = 4,
  parameter int N_OUT      = 2,
  parameter int FRAME_LEN  = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  snn_frame_scheduler_if.master bus,
  output logic                  busy,
  output logic                  err_underflow
`ifdef SNN_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cycles
`endif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CLS_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int SCNT_W = $clog2(FRAME_LEN + 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_NET = 3'd1;
  localparam logic [2:0] ST_RUN      = 3'd2;
  localparam logic [2:0] ST_DRAIN    = 3'd3;
  localparam logic [2:0] ST_RESULT   = 3'd4;

  logic [2:0]        state, state_nx;
  logic [N_IN-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic              full, empty, push, pop, in_run, underflow;
  logic              start_frame, frame_last;
  logic [CNT_W-1:0]  cnt [N_OUT];
  logic [SCNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0]  best_cnt;
  logic [CLS_W-1:0]  best_idx;

  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign in_run      = (state == ST_RUN);
  assign push        = bus.s_valid && !full;
  assign pop         = in_run && bus.net_sample && !empty;
  assign underflow   = in_run && bus.net_sample && empty;
  assign start_frame = (state == ST_IDLE) && enable;
  assign frame_last  = (sample_cnt == SCNT_W'(FRAME_LEN - 1));

  assign bus.s_ready          = !full;
  assign bus.net_sample_ready = in_run && !empty;
  assign bus.net_in_spikes    = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
  assign busy                 = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers use <= so every flop samples pre-edge values regardless of block order.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; the head is masked by empty, so stale words never reach the network.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= bus.s_spikes;
  end

  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    state_nx = state;
    unique case (state)
      ST_IDLE:     if (enable)        state_nx = ST_WAIT_NET;
      ST_WAIT_NET: if (bus.net_ready) state_nx = ST_RUN;
      ST_RUN:      if (pop && frame_last) state_nx = ST_DRAIN;
      ST_DRAIN:    if (bus.net_ready && !bus.net_start) state_nx = ST_RESULT;
      ST_RESULT:   if (bus.res_valid && bus.res_ready) state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  // net_start and res_valid are decoded from the next state so they are flops aligned with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      bus.net_start <= 1'b0;
      bus.res_valid <= 1'b0;
    end else begin
      state         <= state_nx;
      bus.net_start <= (state_nx == ST_RUN);
      bus.res_valid <= (state_nx == ST_RESULT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
    end else if (start_frame) begin
      sample_cnt <= '0;
      for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
    end else if (pop) begin
      sample_cnt <= sample_cnt + 1'b1;
      for (int i = 0; i < N_OUT; i++) begin
        if (bus.net_out_spikes[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err_underflow <= 1'b0;
    else if (underflow) err_underflow <= 1'b1;
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_counts
    assign bus.res_counts[g*CNT_W +: CNT_W] = cnt[g];
  end

  // Strict '>' lets the lowest index win any tie.
  always_comb begin
    best_cnt = cnt[0];
    best_idx = '0;
    for (int i = 1; i < N_OUT; i++) begin
      if (cnt[i] > best_cnt) begin
        best_cnt = cnt[i];
        best_idx = CLS_W'(i);
      end
    end
  end

  assign bus.res_class = best_idx;

`ifdef SNN_SCHED_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        stall_cycles <= '0;
    else if (start_frame)                              stall_cycles <= '0;
    else if (in_run && empty && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_snn_frame_scheduler.sv
// Bench for snn_frame_scheduler: queue-based frame model, directed frame table, corner sequences, random run.
// A second instance with CNT_W=2 shares all stimulus to expose counter saturation.
module tb_snn_frame_scheduler;

  localparam int N_IN       = 4;
  localparam int N_OUT      = 2;
  localparam int FRAME_LEN  = 6;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 8;
  localparam int CNT_W2     = 2;

  typedef enum int {P_IDLE, P_WAIT, P_RUN, P_DRAIN, P_RES} phase_e;

  typedef struct {
    logic [N_OUT-1:0] pa, pb;
    int gap;
    int n0, n1, cls;
    int n0s, n1s, clss;
  } frame_vec_t;

  logic clk = 1'b0;
  logic rst_n, enable, s_valid, net_ready, net_sample, res_ready;
  logic [N_IN-1:0]  s_spikes;
  logic [N_OUT-1:0] net_out_spikes;
  logic busy, err_underflow, busy2, err2;
`ifdef SNN_SCHED_STALL_CNT_EN
  logic [15:0] stall_cycles, stall2;
`endif

  always #5 clk = ~clk;

  snn_frame_scheduler_if #(.N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W))  bus ();
  snn_frame_scheduler_if #(.N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W2)) bus2 ();

  assign bus.s_valid         = s_valid;
  assign bus.s_spikes        = s_spikes;
  assign bus.net_ready       = net_ready;
  assign bus.net_sample      = net_sample;
  assign bus.net_out_spikes  = net_out_spikes;
  assign bus.res_ready       = res_ready;
  assign bus2.s_valid        = s_valid;
  assign bus2.s_spikes       = s_spikes;
  assign bus2.net_ready      = net_ready;
  assign bus2.net_sample     = net_sample;
  assign bus2.net_out_spikes = net_out_spikes;
  assign bus2.res_ready      = res_ready;

  snn_frame_scheduler #(.N_IN(N_IN), .N_OUT(N_OUT), .FRAME_LEN(FRAME_LEN),
                        .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus),
    .busy(busy), .err_underflow(err_underflow)
`ifdef SNN_SCHED_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  snn_frame_scheduler #(.N_IN(N_IN), .N_OUT(N_OUT), .FRAME_LEN(FRAME_LEN),
                        .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus2),
    .busy(busy2), .err_underflow(err2)
`ifdef SNN_SCHED_STALL_CNT_EN
    , .stall_cycles(stall2)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: the FIFO is a queue, counts are unbounded and saturated on compare.
  logic [N_IN-1:0] m_q[$];
  phase_e m_phase;
  int     m_cnt[N_OUT];
  int     m_samples;
  bit     m_err;
  int     m_stall;
  bit     m_pushed;

  bit src_en;
  logic [N_IN-1:0] pending[$], exp_order[$], popped[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  function automatic logic [31:0] exp_counts(input int w);
    logic [31:0] r = '0;
    for (int i = 0; i < N_OUT; i++) r = r | (32'(sat(m_cnt[i], w)) << (i * w));
    return r;
  endfunction

  function automatic logic [31:0] exp_class(input int w);
    int best = sat(m_cnt[0], w);
    int bi = 0;
    for (int i = 1; i < N_OUT; i++) begin
      if (sat(m_cnt[i], w) > best) begin
        best = sat(m_cnt[i], w);
        bi = i;
      end
    end
    return 32'(bi);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_phase = P_IDLE;
    for (int i = 0; i < N_OUT; i++) m_cnt[i] = 0;
    m_samples = 0;
    m_err = 1'b0;
    m_stall = 0;
    m_pushed = 1'b0;
  endtask

  task automatic model_update();
    bit pop, push;
    int occ;
    occ  = m_q.size();
    pop  = (m_phase == P_RUN) && net_sample && (occ > 0);
    push = s_valid && (occ < FIFO_DEPTH);
    m_pushed = push;
    if (m_phase == P_RUN && occ == 0 && m_stall < 65535) m_stall++;
    if (m_phase == P_RUN && net_sample && occ == 0) m_err = 1'b1;
    if (pop) begin
      void'(m_q.pop_front());
      for (int i = 0; i < N_OUT; i++) m_cnt[i] += int'(net_out_spikes[i]);
      m_samples++;
    end
    if (push) m_q.push_back(s_spikes);
    case (m_phase)
      P_IDLE: if (enable) begin
        m_phase = P_WAIT;
        for (int i = 0; i < N_OUT; i++) m_cnt[i] = 0;
        m_samples = 0;
        m_stall = 0;
      end
      P_WAIT:  if (net_ready) m_phase = P_RUN;
      P_RUN:   if (pop && m_samples == FRAME_LEN) m_phase = P_DRAIN;
      P_DRAIN: if (net_ready) m_phase = P_RES;
      P_RES:   if (res_ready) m_phase = P_IDLE;
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic compare_outputs();
    logic [N_IN-1:0] head;
    head = (m_q.size() != 0) ? m_q[0] : '0;
    check("s_ready",          32'(bus.s_ready),          32'(m_q.size() < FIFO_DEPTH));
    check("net_start",        32'(bus.net_start),        32'(m_phase == P_RUN));
    check("net_sample_ready", 32'(bus.net_sample_ready), 32'(m_phase == P_RUN && m_q.size() != 0));
    check("net_in_spikes",    32'(bus.net_in_spikes),    32'(head));
    check("res_valid",        32'(bus.res_valid),        32'(m_phase == P_RES));
    check("busy",             32'(busy),                 32'(m_phase != P_IDLE));
    check("err_underflow",    32'(err_underflow),        32'(m_err));
    check("res_counts",       32'(bus.res_counts),       exp_counts(CNT_W));
    check("res_class",        32'(bus.res_class),        exp_class(CNT_W));
    check("sat_in_spikes",    32'(bus2.net_in_spikes),   32'(head));
    check("sat_busy",         32'(busy2),                32'(m_phase != P_IDLE));
    check("sat_err",          32'(err2),                 32'(m_err));
    check("sat_res_counts",   32'(bus2.res_counts),      exp_counts(CNT_W2));
    check("sat_res_class",    32'(bus2.res_class),       exp_class(CNT_W2));
`ifdef SNN_SCHED_STALL_CNT_EN
    check("stall_cycles",     32'(stall_cycles),         32'(m_stall));
    check("sat_stall_cycles", 32'(stall2),               32'(m_stall));
`endif
  endtask

  // Compare on the falling edge, advance the model, then return just after the rising edge.
  task automatic step();
    @(negedge clk);
    if (!rst_n) model_reset();
    compare_outputs();
    if (rst_n) model_update();
    else m_pushed = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    s_valid  = src_en && (pending.size() > 0);
    s_spikes = (pending.size() > 0) ? pending[0] : '0;
    if (net_sample && m_phase == P_RUN && m_q.size() > 0) popped.push_back(bus.net_in_spikes);
    step();
    if (m_pushed) exp_order.push_back(pending.pop_front());
  endtask

  task automatic run_frame(input logic [N_OUT-1:0] pa, input logic [N_OUT-1:0] pb, input int gap);
    int cyc = 0;
    int drain = 0;
    int n;
    src_en = 1'b1;
    while (m_phase != P_RES && cyc < 1000) begin
      enable         = (m_phase == P_IDLE);
      net_ready      = (m_phase == P_WAIT) || (m_phase == P_DRAIN && drain >= 3);
      if (m_phase == P_DRAIN) drain++;
      net_sample     = (m_phase == P_RUN) && (cyc % gap == gap - 1);
      net_out_spikes = (m_samples % 2 == 0) ? pa : pb;
      res_ready      = 1'b0;
      tick();
      cyc++;
    end
    enable = 1'b0; net_ready = 1'b0; net_sample = 1'b0;
    check("frame_res_valid", 32'(bus.res_valid), 32'd1);
    check("frame_pop_count", 32'(popped.size()), 32'(FRAME_LEN));
    n = popped.size();
    for (int i = 0; i < n; i++)
      check("frame_pop_order", 32'(popped[i]), (i < exp_order.size()) ? 32'(exp_order[i]) : 32'hDEAD);
    for (int i = 0; i < n && exp_order.size() > 0; i++) void'(exp_order.pop_front());
    popped.delete();
  endtask

  task automatic accept_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("idle_after_result", 32'(busy), 32'd0);
  endtask

  task automatic load_pending(input int first);
    logic [N_IN-1:0] data0 [FRAME_LEN];
    data0 = '{4'hF, 4'hE, 4'hD, 4'hC, 4'h0, 4'h0};
    pending.delete();
    for (int k = 0; k < FRAME_LEN; k++) pending.push_back(first != 0 ? data0[k] : N_IN'($urandom));
  endtask

  initial begin
    frame_vec_t tbl [5];
    tbl[0] = '{pa: 2'b01, pb: 2'b01, gap: 10, n0: 6, n1: 0, cls: 0, n0s: 3, n1s: 0, clss: 0};
    tbl[1] = '{pa: 2'b10, pb: 2'b11, gap: 10, n0: 3, n1: 6, cls: 1, n0s: 3, n1s: 3, clss: 0};
    tbl[2] = '{pa: 2'b01, pb: 2'b10, gap: 3,  n0: 3, n1: 3, cls: 0, n0s: 3, n1s: 3, clss: 0};
    tbl[3] = '{pa: 2'b10, pb: 2'b10, gap: 2,  n0: 0, n1: 6, cls: 1, n0s: 0, n1s: 3, clss: 1};
    tbl[4] = '{pa: 2'b00, pb: 2'b00, gap: 4,  n0: 0, n1: 0, cls: 0, n0s: 0, n1s: 0, clss: 0};

    rst_n = 1'b0; enable = 1'b0; net_ready = 1'b0; net_sample = 1'b0; res_ready = 1'b0;
    net_out_spikes = '0; s_valid = 1'b0; s_spikes = '0;
    model_reset();

    // Reset held with a valid sample offered: nothing may enter the FIFO.
    src_en = 1'b1;
    pending.push_back(4'hF);
    repeat (3) begin
      tick();
      check("rst_s_ready",   32'(bus.s_ready),       32'd1);
      check("rst_net_start", 32'(bus.net_start),     32'd0);
      check("rst_res_valid", 32'(bus.res_valid),     32'd0);
      check("rst_busy",      32'(busy),              32'd0);
      check("rst_no_push",   32'(bus.net_in_spikes), 32'd0);
    end
    src_en = 1'b0;
    pending.delete();
    rst_n = 1'b1;
    repeat (2) tick();

    for (int t = 0; t < 5; t++) begin
      load_pending(t == 0 ? 1 : 0);
      run_frame(tbl[t].pa, tbl[t].pb, tbl[t].gap);
      check("tbl_counts",     32'(bus.res_counts),  32'((tbl[t].n1 << CNT_W) | tbl[t].n0));
      check("tbl_class",      32'(bus.res_class),   32'(tbl[t].cls));
      check("tbl_sat_counts", 32'(bus2.res_counts), 32'((tbl[t].n1s << CNT_W2) | tbl[t].n0s));
      check("tbl_sat_class",  32'(bus2.res_class),  32'(tbl[t].clss));
      accept_result();
    end

    // Full FIFO: a pop frees a slot, then push+pop keeps occupancy, then a push refills it.
    load_pending(0);
    src_en = 1'b1; net_out_spikes = 2'b01;
    repeat (4) tick();
    check("full_ready", 32'(bus.s_ready), 32'd0);
    tick();
    check("full_refused_ready", 32'(bus.s_ready), 32'd0);
    enable = 1'b1; tick(); enable = 1'b0;
    net_ready = 1'b1; tick(); net_ready = 1'b0;
    check("run_start", 32'(bus.net_start), 32'd1);
    net_sample = 1'b1; tick();
    check("pop_at_full_ready", 32'(bus.s_ready), 32'd1);
    tick();
    check("push_pop_ready", 32'(bus.s_ready), 32'd1);
    net_sample = 1'b0; tick();
    check("refill_full", 32'(bus.s_ready), 32'd0);
    run_frame(2'b01, 2'b10, 4);
    check("full_counts",     32'(bus.res_counts),  32'((2 << CNT_W) | 4));
    check("full_sat_counts", 32'(bus2.res_counts), 32'((2 << CNT_W2) | 3));
    accept_result();
    load_pending(0);
    run_frame(2'b11, 2'b11, 2);
    check("wrap_counts", 32'(bus.res_counts), 32'((6 << CNT_W) | 6));
    check("wrap_class",  32'(bus.res_class),  32'd0);
    accept_result();

    // Underflow and stall: RUN entered with an empty FIFO for five cycles.
    check("err_clear_before", 32'(err_underflow), 32'd0);
    pending.delete(); src_en = 1'b0;
    enable = 1'b1; tick(); enable = 1'b0;
    net_ready = 1'b1; tick(); net_ready = 1'b0;
    check("start_latency", 32'(bus.net_start),        32'd1);
    check("nsr_empty",     32'(bus.net_sample_ready), 32'd0);
    tick(); tick();
    net_sample = 1'b1; net_out_spikes = 2'b11; tick(); net_sample = 1'b0;
    tick(); tick();
    check("underflow_err",    32'(err_underflow),   32'd1);
    check("underflow_counts", 32'(bus.res_counts),  32'd0);
`ifdef SNN_SCHED_STALL_CNT_EN
    check("stall_five", 32'(stall_cycles), 32'd5);
`endif
    load_pending(0);
    run_frame(2'b01, 2'b01, 3);
    check("after_underflow_counts", 32'(bus.res_counts),  32'd6);
    check("after_underflow_sat",    32'(bus2.res_counts), 32'd3);
    accept_result();
    check("err_sticky", 32'(err_underflow), 32'd1);

    // Asynchronous reset in the middle of RUN.
    load_pending(0); src_en = 1'b1;
    enable = 1'b1; tick(); enable = 1'b0;
    net_ready = 1'b1; tick(); net_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",      32'(busy),                 32'd0);
    check("mid_rst_start",     32'(bus.net_start),        32'd0);
    check("mid_rst_s_ready",   32'(bus.s_ready),          32'd1);
    check("mid_rst_res_valid", 32'(bus.res_valid),        32'd0);
    check("mid_rst_err",       32'(err_underflow),        32'd0);
    check("mid_rst_nsr",       32'(bus.net_sample_ready), 32'd0);
    check("mid_rst_in",        32'(bus.net_in_spikes),    32'd0);
    src_en = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    pending.delete(); exp_order.delete(); popped.delete();
    tick();

    // Random traffic against the model, with occasional resets.
    repeat (3000) begin
      rst_n          = ($urandom_range(0, 299) != 0);
      enable         = ($urandom_range(0, 3) == 0);
      s_valid        = $urandom_range(0, 1) != 0;
      s_spikes       = N_IN'($urandom);
      net_ready      = ($urandom_range(0, 2) == 0);
      net_sample     = ($urandom_range(0, 2) == 0);
      net_out_spikes = N_OUT'($urandom);
      res_ready      = $urandom_range(0, 1) != 0;
      step();
    end
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule
